ps2_scancode_decoder: RTL and testbench

//  Consumes the byte stream from the PS/2 receiver (data byte + one-cycle ready strobe).

---
 rtl/ps2_scancode_decoder_pkg.sv | 41 ++++
 rtl/ps2_scancode_decoder_if.sv | 36 +++
 rtl/ps2_scancode_decoder_sc2ascii.sv | 74 +++++++
 rtl/ps2_scancode_decoder.sv | 170 +++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_scancode_decoder_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
//   Shared constants for the PS/2 set-2 scancode decoder: prefix bytes,
//   modifier scancodes, keyboard status bytes and the decoder FSM encoding.
//   There are no ports. The package provides the constants, the state type and
//   a status-byte classifier.
// -----------------------------------------------------------------------------
package ps2_pkg;

   localparam logic [7:0] SC_E0       = 8'hE0;
   localparam logic [7:0] SC_F0       = 8'hF0;
   localparam logic [7:0] SC_LSHIFT   = 8'h12;
   localparam logic [7:0] SC_RSHIFT   = 8'h59;
   localparam logic [7:0] SC_CAPS     = 8'h58;

   // Keyboard-to-host status bytes. They never form part of a key event.
   localparam logic [7:0] SC_ST_BAT   = 8'hAA;
   localparam logic [7:0] SC_ST_ACK   = 8'hFA;
   localparam logic [7:0] SC_ST_RSND  = 8'hFE;
   localparam logic [7:0] SC_ST_ERR0  = 8'h00;
   localparam logic [7:0] SC_ST_ERR1  = 8'hFF;

   // In the FSM encoding, bit 0 means E0 was seen and bit 1 means F0 was seen.
   localparam logic [1:0] ENC_IDLE     = 2'd0;
   localparam logic [1:0] ENC_PRE_E0   = 2'd1;
   localparam logic [1:0] ENC_PRE_F0   = 2'd2;
   localparam logic [1:0] ENC_PRE_E0F0 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = ENC_IDLE,
      ST_PRE_E0   = ENC_PRE_E0,
      ST_PRE_F0   = ENC_PRE_F0,
      ST_PRE_E0F0 = ENC_PRE_E0F0
   } state_t;

   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == SC_ST_BAT) || (b == SC_ST_ACK) || (b == SC_ST_RSND) ||
             (b == SC_ST_ERR0) || (b == SC_ST_ERR1);
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// -----------------------------------------------------------------------------
// ps2_scancode_decoder_if
//   This interface carries the byte stream from the receiver and the decoded
//   key event to the consumers.
//   Handshake: scan_valid is a one-cycle strobe, and scan_data is sampled only
//   while scan_valid=1. There is no back-pressure. key_valid is a one-cycle
//   strobe. The key_* and ascii fields stay stable until the next strobe.
//   Modports:
//     master - drives scan_data/scan_valid/scan_ovf, observes the key event
//     slave  - the decoder: consumes the scan bytes, produces the key event
// -----------------------------------------------------------------------------
interface ps2_scancode_decoder_if;
   logic [7:0] scan_data;
   logic       scan_valid;
   logic       scan_ovf;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_break;
   logic       key_ext;
   logic       key_repeat;
   logic [7:0] ascii;
   logic       shift_held;
   logic       caps_lock;

   modport master (
      output scan_data, scan_valid, scan_ovf,
      input  key_valid, key_code, key_break, key_ext, key_repeat, ascii,
             shift_held, caps_lock
   );

   modport slave (
      input  scan_data, scan_valid, scan_ovf,
      output key_valid, key_code, key_break, key_ext, key_repeat, ascii,
             shift_held, caps_lock
   );
endinterface

// File: rtl/ps2_scancode_decoder_sc2ascii.sv
// -----------------------------------------------------------------------------
// ps2_sc2ascii
//   This block is a combinational set-2 scancode to ASCII table.
//   Ports:
//     i_code  [7:0] final scancode (no prefix)
//     i_shift       a shift key is held
//     i_caps        caps-lock toggle state
//     o_ascii [7:0] ASCII character, 8'h00 when the code is unmapped
//   Letters use upper case when exactly one of shift and caps-lock is active.
//   Digits react only to shift.
// -----------------------------------------------------------------------------
module ps2_sc2ascii (
   input  logic [7:0] i_code,
   input  logic       i_shift,
   input  logic       i_caps,
   output logic [7:0] o_ascii
);

   logic w_upper;
   assign w_upper = i_shift ^ i_caps;

   function automatic logic [7:0] letter(input logic [7:0] lower, input logic up);
      return up ? (lower - 8'h20) : lower;
   endfunction

   always_comb begin
      o_ascii = 8'h00;
      case (i_code)
         8'h1C: o_ascii = letter(8'h61, w_upper);
         8'h32: o_ascii = letter(8'h62, w_upper);
         8'h21: o_ascii = letter(8'h63, w_upper);
         8'h23: o_ascii = letter(8'h64, w_upper);
         8'h24: o_ascii = letter(8'h65, w_upper);
         8'h2B: o_ascii = letter(8'h66, w_upper);
         8'h34: o_ascii = letter(8'h67, w_upper);
         8'h33: o_ascii = letter(8'h68, w_upper);
         8'h43: o_ascii = letter(8'h69, w_upper);
         8'h3B: o_ascii = letter(8'h6A, w_upper);
         8'h42: o_ascii = letter(8'h6B, w_upper);
         8'h4B: o_ascii = letter(8'h6C, w_upper);
         8'h3A: o_ascii = letter(8'h6D, w_upper);
         8'h31: o_ascii = letter(8'h6E, w_upper);
         8'h44: o_ascii = letter(8'h6F, w_upper);
         8'h4D: o_ascii = letter(8'h70, w_upper);
         8'h15: o_ascii = letter(8'h71, w_upper);
         8'h2D: o_ascii = letter(8'h72, w_upper);
         8'h1B: o_ascii = letter(8'h73, w_upper);
         8'h2C: o_ascii = letter(8'h74, w_upper);
         8'h3C: o_ascii = letter(8'h75, w_upper);
         8'h2A: o_ascii = letter(8'h76, w_upper);
         8'h1D: o_ascii = letter(8'h77, w_upper);
         8'h22: o_ascii = letter(8'h78, w_upper);
         8'h35: o_ascii = letter(8'h79, w_upper);
         8'h1A: o_ascii = letter(8'h7A, w_upper);
         8'h45: o_ascii = i_shift ? 8'h29 : 8'h30;   // 0 )
         8'h16: o_ascii = i_shift ? 8'h21 : 8'h31;   // 1 !
         8'h1E: o_ascii = i_shift ? 8'h40 : 8'h32;   // 2 @
         8'h26: o_ascii = i_shift ? 8'h23 : 8'h33;   // 3 #
         8'h25: o_ascii = i_shift ? 8'h24 : 8'h34;   // 4 $
         8'h2E: o_ascii = i_shift ? 8'h25 : 8'h35;   // 5 %
         8'h36: o_ascii = i_shift ? 8'h5E : 8'h36;   // 6 ^
         8'h3D: o_ascii = i_shift ? 8'h26 : 8'h37;   // 7 &
         8'h3E: o_ascii = i_shift ? 8'h2A : 8'h38;   // 8 *
         8'h46: o_ascii = i_shift ? 8'h28 : 8'h39;   // 9 (
         8'h29: o_ascii = 8'h20;
         8'h5A: o_ascii = 8'h0D;
         8'h66: o_ascii = 8'h08;
         8'h0D: o_ascii = 8'h09;
         8'h76: o_ascii = 8'h1B;
         default: o_ascii = 8'h00;
      endcase
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// -----------------------------------------------------------------------------
// ps2_scancode_decoder
//   This block turns the PS/2 set-2 byte stream into key events. It resolves
//   the E0 (extended) and F0 (break) prefixes, tracks the shift and caps-lock
//   state, flags typematic repeats and produces ASCII.
//   Parameter:
//     TIMEOUT_CYCLES  number of cycles a pending prefix waits before it is dropped
//   Ports:
//     clk          system clock, rising edge
//     clr          asynchronous active-high reset
//     io_ps2       slave modport: scan_data/scan_valid/scan_ovf in;
//                  key_valid/key_code/key_break/key_ext/key_repeat/ascii,
//                  shift_held, caps_lock out (all registered)
//     o_dbg_state  current FSM state
// -----------------------------------------------------------------------------
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                   clk,
   input  logic                   clr,
   ps2_scancode_decoder_if.slave  io_ps2,
   output state_t                 o_dbg_state
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_key_valid;
   logic [7:0]    r_key_code;
   logic          r_key_break;
   logic          r_key_ext;
   logic          r_key_repeat;
   logic [7:0]    r_ascii;
   logic          r_shift_l;
   logic          r_shift_r;
   logic          r_caps_lock;
   logic          r_caps_held;
   logic [8:0]    r_last_make;   // {ext, code} of the most recent make

   logic          w_byte;
   logic          w_is_prefix;
   logic          w_emit;
   logic          w_brk;
   logic          w_ext;
   logic          w_shift_held;
   logic [7:0]    w_ascii;
   logic [8:0]    w_evt_id;

   // While overflow is high, bytes are ignored.
   assign w_byte       = io_ps2.scan_valid & ~io_ps2.scan_ovf;
   assign w_is_prefix  = (io_ps2.scan_data == SC_E0) || (io_ps2.scan_data == SC_F0);
   assign w_shift_held = r_shift_l | r_shift_r;
   assign w_evt_id     = {w_ext, io_ps2.scan_data};

   // This logic decides whether the current byte completes an event, and what kind.
   always_comb begin
      w_emit = 1'b0;
      w_brk  = 1'b0;
      w_ext  = 1'b0;
      if (w_byte && !w_is_prefix) begin
         case (r_state)
            ST_IDLE:     w_emit = !is_status_byte(io_ps2.scan_data);
            ST_PRE_E0:   begin w_emit = 1'b1; w_ext = 1'b1; end
            ST_PRE_F0:   begin w_emit = 1'b1; w_brk = 1'b1; end
            ST_PRE_E0F0: begin w_emit = 1'b1; w_brk = 1'b1; w_ext = 1'b1; end
            default:     w_emit = 1'b0;
         endcase
      end
   end

   // The table looks at the shift state from before this event, so the shift
   // make/break event uses the old state.
   ps2_sc2ascii u_sc2ascii (
      .i_code  (io_ps2.scan_data),
      .i_shift (w_shift_held),
      .i_caps  (r_caps_lock),
      .o_ascii (w_ascii)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_key_valid  <= 1'b0;
         r_key_code   <= 8'h00;
         r_key_break  <= 1'b0;
         r_key_ext    <= 1'b0;
         r_key_repeat <= 1'b0;
         r_ascii      <= 8'h00;
         r_shift_l    <= 1'b0;
         r_shift_r    <= 1'b0;
         r_caps_lock  <= 1'b0;
         r_caps_held  <= 1'b0;
         r_last_make  <= 9'h000;
      end else begin
         r_key_valid <= w_emit;

         if (io_ps2.scan_ovf) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
         end else if (io_ps2.scan_valid) begin
            // An arriving byte restarts the timer, even in the cycle the timer would expire.
            r_timer <= '0;
            if (io_ps2.scan_data == SC_E0) begin
               case (r_state)
                  ST_PRE_F0, ST_PRE_E0F0: r_state <= ST_PRE_E0F0;
                  default:                r_state <= ST_PRE_E0;
               endcase
            end else if (io_ps2.scan_data == SC_F0) begin
               case (r_state)
                  ST_PRE_E0, ST_PRE_E0F0: r_state <= ST_PRE_E0F0;
                  default:                r_state <= ST_PRE_F0;
               endcase
            end else begin
               r_state <= ST_IDLE;
            end
         end else if (r_state != ST_IDLE) begin
            if (r_timer == TIMER_LAST) begin
               r_state <= ST_IDLE;
               r_timer <= '0;
            end else begin
               r_timer <= r_timer + 1'b1;
            end
         end

         if (w_emit) begin
            r_key_code   <= io_ps2.scan_data;
            r_key_break  <= w_brk;
            r_key_ext    <= w_ext;
            r_ascii      <= w_ext ? 8'h00 : w_ascii;
            r_key_repeat <= !w_brk && (w_evt_id == r_last_make);
            if (!w_brk)
               r_last_make <= w_evt_id;
            else if (w_evt_id == r_last_make)
               r_last_make <= 9'h000;

            if (!w_ext) begin
               if (!w_brk) begin
                  if (io_ps2.scan_data == SC_LSHIFT) r_shift_l <= 1'b1;
                  if (io_ps2.scan_data == SC_RSHIFT) r_shift_r <= 1'b1;
                  // caps_held stops typematic repeats of caps-lock from toggling it again.
                  if (io_ps2.scan_data == SC_CAPS && !r_caps_held) begin
                     r_caps_lock <= ~r_caps_lock;
                     r_caps_held <= 1'b1;
                  end
               end else begin
                  if (io_ps2.scan_data == SC_LSHIFT) r_shift_l   <= 1'b0;
                  if (io_ps2.scan_data == SC_RSHIFT) r_shift_r   <= 1'b0;
                  if (io_ps2.scan_data == SC_CAPS)   r_caps_held <= 1'b0;
               end
            end
         end
      end
   end

   assign io_ps2.key_valid  = r_key_valid;
   assign io_ps2.key_code   = r_key_code;
   assign io_ps2.key_break  = r_key_break;
   assign io_ps2.key_ext    = r_key_ext;
   assign io_ps2.key_repeat = r_key_repeat;
   assign io_ps2.ascii      = r_ascii;
   assign io_ps2.shift_held = w_shift_held;
   assign io_ps2.caps_lock  = r_caps_lock;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_scancode_decoder
//   This is the self-checking bench for ps2_scancode_decoder with TIMEOUT_CYCLES=16.
//   The reference model tracks the pending prefixes as two flags. It pushes
//   {break, ext, repeat, code, ascii} onto exp_q whenever a byte completes an
//   event. The monitor pops the queue on each key_valid strobe.
// -----------------------------------------------------------------------------
module tb_ps2_scancode_decoder;
   import ps2_pkg::*;

   localparam int W = 19;

   logic   clk = 1'b0;
   logic   clr = 1'b1;
   state_t dbg_state;

   ps2_scancode_decoder_if ifc ();

   ps2_scancode_decoder #(.TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .clr         (clr),
      .io_ps2      (ifc),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] exp_q[$];
   logic       m_ext, m_brk, m_sl, m_sr, m_caps, m_caps_held;
   logic [8:0] m_last;

   logic [7:0] lc_tab  [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                8'h35, 8'h1A};
   logic [7:0] dg_tab  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};
   logic [7:0] sym_tab [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                8'h2A, 8'h28};

   function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic sh, input logic cp);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 26; i++)
         if (c == lc_tab[i]) r = ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (c == dg_tab[i]) r = sh ? sym_tab[i] : 8'h30 + 8'(i);
      case (c)
         8'h29: r = 8'h20;
         8'h5A: r = 8'h0D;
         8'h66: r = 8'h08;
         8'h0D: r = 8'h09;
         8'h76: r = 8'h1B;
         default: ;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_sl = 0; m_sr = 0; m_caps = 0; m_caps_held = 0; m_last = 9'h0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] asc;
      logic       rep;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (!m_ext && !m_brk &&
               (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
      end else begin
         asc = m_ext ? 8'h00 : ref_ascii(b, m_sl | m_sr, m_caps);
         rep = !m_brk && ({m_ext, b} == m_last);
         exp_q.push_back({m_brk, m_ext, rep, b, asc});
         if (!m_brk) m_last = {m_ext, b};
         else if ({m_ext, b} == m_last) m_last = 9'h0;
         if (!m_ext) begin
            if (!m_brk) begin
               if (b == 8'h12) m_sl = 1;
               if (b == 8'h59) m_sr = 1;
               if (b == 8'h58 && !m_caps_held) begin m_caps = ~m_caps; m_caps_held = 1; end
            end else begin
               if (b == 8'h12) m_sl = 0;
               if (b == 8'h59) m_sr = 0;
               if (b == 8'h58) m_caps_held = 0;
            end
         end
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b);
      model_byte(b);
      @(negedge clk);
      ifc.scan_data  = b;
      ifc.scan_valid = 1'b1;
      @(negedge clk);
      ifc.scan_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_mods(input string tag);
      check({tag, "_shift"}, 32'(ifc.shift_held), 32'(m_sl | m_sr));
      check({tag, "_caps"},  32'(ifc.caps_lock),  32'(m_caps));
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [W-1:0] mon_e;
   always @(negedge clk) begin
      if (ifc.key_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", 32'(ifc.key_code), 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check("key_code",   32'(ifc.key_code),   32'(mon_e[15:8]));
            check("key_break",  32'(ifc.key_break),  32'(mon_e[18]));
            check("key_ext",    32'(ifc.key_ext),    32'(mon_e[17]));
            check("key_repeat", 32'(ifc.key_repeat), 32'(mon_e[16]));
            check("ascii",      32'(ifc.ascii),      32'(mon_e[7:0]));
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},  32'(ifc.key_valid),  32'h0);
      check({tag, "_code"},   32'(ifc.key_code),   32'h0);
      check({tag, "_break"},  32'(ifc.key_break),  32'h0);
      check({tag, "_ext"},    32'(ifc.key_ext),    32'h0);
      check({tag, "_repeat"}, 32'(ifc.key_repeat), 32'h0);
      check({tag, "_ascii"},  32'(ifc.ascii),      32'h0);
      check({tag, "_shift"},  32'(ifc.shift_held), 32'h0);
      check({tag, "_caps"},   32'(ifc.caps_lock),  32'h0);
      check({tag, "_state"},  32'(dbg_state),      32'(ST_IDLE));
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] pool [16] = '{8'h1C, 8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'h16, 8'h45,
                             8'h29, 8'h5A, 8'hAA, 8'h32, 8'h3E, 8'h75, 8'h1C, 8'hF0};

   initial begin
      ifc.scan_data  = 8'h00;
      ifc.scan_valid = 1'b0;
      ifc.scan_ovf   = 1'b0;
      model_reset();
      idle(3);
      check_reset_outputs("rst");
      clr = 1'b0;
      idle(2);

      // Plain make
      send_byte(8'h1C);
      idle(2);

      // Shifted A, make and break, and the shift lifecycle
      send_byte(8'h12);
      check_mods("after_lshift_make");
      send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h12);
      check_mods("after_lshift_break");

      // Extended make and break; prefixes alone produce no event
      send_byte(8'hE0);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);

      // Caps-lock toggles once, repeat flagged, letter goes upper case
      send_byte(8'h58);
      check_mods("caps_first");
      send_byte(8'h58);
      check_mods("caps_repeat");
      send_byte(8'hF0);
      send_byte(8'h58);
      send_byte(8'h1C);
      send_byte(8'h1C);

      // A status byte in IDLE produces nothing
      send_byte(8'hAA);
      check("status_state", 32'(dbg_state), 32'(ST_IDLE));

      // Timeout drops a pending F0
      send_byte(8'hF0);
      check("pend_state", 32'(dbg_state), 32'(ST_PRE_F0));
      idle(20);
      check("timeout_state", 32'(dbg_state), 32'(ST_IDLE));
      m_brk = 0;
      send_byte(8'h1C);

      // A byte arriving in the expiry cycle wins
      send_byte(8'hF0);
      idle(14);
      send_byte(8'h1C);

      // An overflow pulse drops a pending F0
      send_byte(8'hF0);
      @(negedge clk); ifc.scan_ovf = 1'b1;
      @(negedge clk); ifc.scan_ovf = 1'b0;
      m_brk = 0;
      send_byte(8'h1C);

      // A byte is ignored while overflow is high
      @(negedge clk);
      ifc.scan_ovf   = 1'b1;
      ifc.scan_data  = 8'h32;
      ifc.scan_valid = 1'b1;
      @(negedge clk);
      ifc.scan_valid = 1'b0;
      ifc.scan_ovf   = 1'b0;
      idle(2);

      // Random byte mix with the modifier state checked after each byte
      for (int i = 0; i < 60; i++) begin
         send_byte(pool[$urandom_range(0, 15)]);
         check_mods("rand");
      end
      idle(20);
      m_ext = 0;
      m_brk = 0;

      // Reset mid-sequence
      send_byte(8'h58);
      send_byte(8'hE0);
      idle(1);
      clr = 1'b1;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      idle(2);
      clr = 1'b0;
      send_byte(8'h1C);
      idle(4);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
